// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory arbiter and the data memory itself.
//   - access size encodings
//   - arbiter state encoding
//   - request bundle carried through the arbiter mux
//   - misalignment rule (the arbiter and the memory both call it so they agree
//     on which accesses are illegal)
// -----------------------------------------------------------------------------
package dmem_pkg;

  // Access size encodings; 2'b11 is reserved and always rejected.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Arbiter state encoding.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_OWN0 = 2'b01;
  localparam logic [1:0] ST_OWN1 = 2'b10;

  // One requester's access, as presented to the memory.
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wd;
  } dmem_req_t;

  // Natural alignment: halves on even addresses, words on multiples of four.
  function automatic logic misaligned(input logic [1:0] size,
                                      input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_misalign_chk.sv
// -----------------------------------------------------------------------------
// dmem_misalign_chk
// Combinational misalignment detector for one memory access.
// Ports:
//   size_i     [1:0]  access size (byte/half/word/reserved)
//   addr_lo_i  [1:0]  low two bits of the byte address
//   misalign_o        1 = access violates natural alignment or size is reserved
// -----------------------------------------------------------------------------
module dmem_misalign_chk
  import dmem_pkg::*;
(
  input  logic [1:0] size_i,
  input  logic [1:0] addr_lo_i,
  output logic       misalign_o
);

  assign misalign_o = misaligned(size_i, addr_lo_i);

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-cycle data memory between the core load/store path
// (port 0) and the DMA/debug requester (port 1). At most one access is issued
// per cycle; the granted request is muxed onto the memory inputs and its
// response (rvalid/rdata/err) is registered back to that port one cycle later.
// A port may keep ownership for a short locked sequence (e.g. read-modify-
// write), bounded by MAX_HOLD consecutive grants.
//
// Parameters:
//   MAX_HOLD   max consecutive grants in one locked sequence (>= 1)
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   reqN, lockN                      request (held until gnt), keep ownership
//   weN, sizeN, sextN, addrN, wdN    access description per port
//   gntN                             combinational: access issued this cycle
//   rvalidN, rdataN, errN            registered response, one cycle after gnt
//   mem_we/size/sext/addr/wd         drive to the memory (all 0 when idle)
//   mem_rd                           combinational read data from the memory
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0,
  input  logic        lock0,
  input  logic        we0,
  input  logic [1:0]  size0,
  input  logic        sext0,
  input  logic [31:0] addr0,
  input  logic [31:0] wd0,

  input  logic        req1,
  input  logic        lock1,
  input  logic        we1,
  input  logic [1:0]  size1,
  input  logic        sext1,
  input  logic [31:0] addr1,
  input  logic [31:0] wd1,

  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,

  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic        mem_sext,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam int unsigned       HOLD_W     = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
  // With a limit of one, the first grant already exhausts the sequence, so
  // lock never moves the arbiter into an ownership state.
  localparam bit                CAN_LOCK   = (MAX_HOLD > 1);

  // Control state
  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] hold_inc;

  // Response registers
  logic              rvalid0_q, rvalid1_q;
  logic              err0_q, err1_q;
  logic [31:0]       rdata0_q, rdata1_q;

  // Arbitration result
  logic              sel;       // port whose request is muxed to the memory
  logic              gnt_any;   // a grant is issued (before reset gating)
  logic              gnt;
  logic              lock_sel;
  logic              req_sel;

  dmem_req_t         req_p0, req_p1, req_m;
  logic              misalign;
  logic [31:0]       resp_data;

  assign req_p0 = '{we: we0, size: size0, sext: sext0, addr: addr0, wd: wd0};
  assign req_p1 = '{we: we1, size: size1, sext: sext1, addr: addr1, wd: wd1};

  assign hold_inc = hold_q + HOLD_ONE;
  assign lock_sel = sel ? lock1 : lock0;
  assign req_sel  = sel ? req1  : req0;

  // ---- arbitration / next state ----
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    sel     = 1'b0;
    gnt_any = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0 | req1) begin
          gnt_any = 1'b1;
          // Under contention the port that did not win last time goes next.
          sel     = (req0 & req1) ? ~last_q : req1;
          last_d  = sel;
          if (lock_sel && CAN_LOCK) begin
            state_d = sel ? ST_OWN1 : ST_OWN0;
            hold_d  = HOLD_ONE;
          end
        end
      end
      ST_OWN0, ST_OWN1: begin
        // The owner is the only candidate; the other port's request waits.
        sel = (state_q == ST_OWN1);
        if (req_sel) begin
          gnt_any = 1'b1;
          hold_d  = hold_inc;
          if (!lock_sel || (hold_inc >= HOLD_LIMIT)) begin
            state_d = ST_IDLE;
            hold_d  = '0;
          end
        end else begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = '0;
      end
    endcase
  end

  // Reset also silences the combinational grant so nothing reaches the
  // memory while rst is high.
  assign gnt  = gnt_any & ~rst;
  assign gnt0 = gnt & ~sel;
  assign gnt1 = gnt &  sel;

  // ---- memory drive (grant cycle) ----
  assign req_m = sel ? req_p1 : req_p0;

  dmem_misalign_chk u_misalign_chk (
    .size_i     (req_m.size),
    .addr_lo_i  (req_m.addr[1:0]),
    .misalign_o (misalign)
  );

  // A misaligned store is still granted and answered, but never written.
  assign mem_we   = gnt & req_m.we & ~misalign;
  assign mem_size = gnt ? req_m.size : 2'b00;
  assign mem_sext = gnt & req_m.sext;
  assign mem_addr = gnt ? req_m.addr : 32'h0;
  assign mem_wd   = gnt ? req_m.wd   : 32'h0;

  assign resp_data = (req_m.we | misalign) ? 32'h0 : mem_rd;

  // ---- response stage (registered at the grant edge) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;
      hold_q    <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= 32'h0;
      rdata1_q  <= 32'h0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      rvalid0_q <= gnt0;
      rvalid1_q <= gnt1;
      err0_q    <= gnt0 & misalign;
      err1_q    <= gnt1 & misalign;
      rdata0_q  <= gnt0 ? resp_data : 32'h0;
      rdata1_q  <= gnt1 ? resp_data : 32'h0;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign err0    = err0_q;
  assign err1    = err1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Bench for dmem_arbiter: a small word-array memory sits on the mem_* bus,
// directed scenarios exercise contention, locking, hold limit, misalignment,
// sign extension and reset, followed by randomized traffic. A reference model
// of the arbitration rules and of memory contents predicts every grant, memory
// drive and response.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Stimulus, indexed by port
  logic [1:0]  t_req, t_lock, t_we, t_sext;
  logic [1:0]  t_size [2];
  logic [31:0] t_addr [2];
  logic [31:0] t_wd   [2];

  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_we, mem_sext;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  dmem_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst),
    .req0(t_req[0]), .lock0(t_lock[0]), .we0(t_we[0]), .size0(t_size[0]),
    .sext0(t_sext[0]), .addr0(t_addr[0]), .wd0(t_wd[0]),
    .req1(t_req[1]), .lock1(t_lock[1]), .we1(t_we[1]), .size1(t_size[1]),
    .sext1(t_sext[1]), .addr1(t_addr[1]), .wd1(t_wd[1]),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .mem_we(mem_we), .mem_size(mem_size), .mem_sext(mem_sext),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Memory load/store lane handling (byte / half / word)
  function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [1:0] sz,
                                         input logic sx, input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   return sx ? {{24{b[7]}}, b} : {24'h0, b};
      2'b01:   return sx ? {{16{h[15]}}, h} : {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] st_merge(input logic [31:0] old, input logic [31:0] d,
                                           input logic [1:0] sz, input logic [1:0] a);
    logic [31:0] r;
    r = old;
    case (sz)
      2'b00:   r[{a, 3'b000} +: 8] = d[7:0];
      2'b01:   if (a[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  // Memory attached to the DUT (16 words, combinational read)
  logic [31:0] env_mem [16];
  logic        mem_clr;
  assign mem_rd = ld_ext(env_mem[mem_addr[5:2]], mem_size, mem_sext, mem_addr[1:0]);
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) env_mem[i] <= 32'h0;
    end else if (mem_we) begin
      env_mem[mem_addr[5:2]] <= st_merge(env_mem[mem_addr[5:2]], mem_wd, mem_size, mem_addr[1:0]);
    end
  end

  // Reference model state
  int          own;    // -1 = no owner, else port holding a locked sequence
  int          run;    // grants in the current locked sequence
  int          last;   // last granted port
  logic [31:0] ref_mem [16];

  int checks, errors;
  logic        obs_g0, obs_g1, obs_mwe, obs_err0, obs_rv0;
  logic [31:0] obs_rd0;

  task automatic chk(input string tag, input string what,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s: observed %0h expected %0h", tag, what, obs, exp);
    end
  endtask

  task automatic model_reset();
    own = -1; run = 0; last = 1;
  endtask

  task automatic setp(input int p, input logic r, input logic l, input logic w,
                      input logic [1:0] s, input logic x, input logic [31:0] a,
                      input logic [31:0] d);
    t_req[p] = r; t_lock[p] = l; t_we[p] = w; t_size[p] = s;
    t_sext[p] = x; t_addr[p] = a; t_wd[p] = d;
  endtask

  task automatic idle_all();
    setp(0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    setp(1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  // One clock cycle: predict, check the grant-cycle outputs, step the clock,
  // check the registered response.
  task automatic cyc(input string tag);
    int          g;
    logic        bad;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [1:0]  e_rv, e_err;
    logic [31:0] e_rd [2];
    #3;
    g = -1;
    if (own >= 0) begin
      if (t_req[own]) begin
        g = own;
        run++;
        if (!t_lock[own] || run >= MAX_HOLD) begin own = -1; run = 0; end
      end else begin
        own = -1; run = 0;
      end
    end else if (t_req != 2'b00) begin
      g = (t_req == 2'b11) ? 1 - last : (t_req[0] ? 0 : 1);
      last = g;
      if (t_lock[g] && MAX_HOLD > 1) begin own = g; run = 1; end
    end
    e_rv = 2'b00; e_err = 2'b00; e_rd[0] = 32'h0; e_rd[1] = 32'h0;
    chk(tag, "gnt0", 32'(gnt0), 32'(g == 0));
    chk(tag, "gnt1", 32'(gnt1), 32'(g == 1));
    if (g >= 0) begin
      sz  = t_size[g];
      a   = t_addr[g];
      bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
      chk(tag, "mem_we",   32'(mem_we),   32'(t_we[g] && !bad));
      chk(tag, "mem_size", 32'(mem_size), 32'(sz));
      chk(tag, "mem_sext", 32'(mem_sext), 32'(t_sext[g]));
      chk(tag, "mem_addr", mem_addr, a);
      chk(tag, "mem_wd",   mem_wd,   t_wd[g]);
      e_rv[g]  = 1'b1;
      e_err[g] = bad;
      if (!t_we[g] && !bad) e_rd[g] = ld_ext(ref_mem[a[5:2]], sz, t_sext[g], a[1:0]);
      if (t_we[g] && !bad) ref_mem[a[5:2]] = st_merge(ref_mem[a[5:2]], t_wd[g], sz, a[1:0]);
    end else begin
      chk(tag, "mem_we",   32'(mem_we),   32'h0);
      chk(tag, "mem_size", 32'(mem_size), 32'h0);
      chk(tag, "mem_sext", 32'(mem_sext), 32'h0);
      chk(tag, "mem_addr", mem_addr, 32'h0);
      chk(tag, "mem_wd",   mem_wd,   32'h0);
    end
    obs_g0 = gnt0; obs_g1 = gnt1; obs_mwe = mem_we;
    @(posedge clk);
    #1;
    chk(tag, "rvalid0", 32'(rvalid0), 32'(e_rv[0]));
    chk(tag, "rvalid1", 32'(rvalid1), 32'(e_rv[1]));
    chk(tag, "err0",    32'(err0),    32'(e_err[0]));
    chk(tag, "err1",    32'(err1),    32'(e_err[1]));
    chk(tag, "rdata0",  rdata0, e_rd[0]);
    chk(tag, "rdata1",  rdata1, e_rd[1]);
    obs_rd0 = rdata0; obs_err0 = err0; obs_rv0 = rvalid0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, "gnt0",     32'(gnt0),     32'h0);
    chk(tag, "gnt1",     32'(gnt1),     32'h0);
    chk(tag, "rvalid0",  32'(rvalid0),  32'h0);
    chk(tag, "rvalid1",  32'(rvalid1),  32'h0);
    chk(tag, "err0",     32'(err0),     32'h0);
    chk(tag, "err1",     32'(err1),     32'h0);
    chk(tag, "rdata0",   rdata0,        32'h0);
    chk(tag, "rdata1",   rdata1,        32'h0);
    chk(tag, "mem_we",   32'(mem_we),   32'h0);
    chk(tag, "mem_size", 32'(mem_size), 32'h0);
    chk(tag, "mem_sext", 32'(mem_sext), 32'h0);
    chk(tag, "mem_addr", mem_addr,      32'h0);
    chk(tag, "mem_wd",   mem_wd,        32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n0;
    logic saw_g1;
    checks = 0; errors = 0;
    mem_clr = 1'b1;
    rst = 1'b1;
    idle_all();
    model_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;

    // Reset state, with requests present that must not be granted
    t_req = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    idle_all();
    mem_clr = 1'b0;
    rst = 1'b0;

    // Contention after reset: 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      setp(0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
      setp(1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h24, 32'h0);
      cyc("cont");
      chk("cont", "alt_gnt0", 32'(obs_g0), 32'(i % 2 == 0));
      chk("cont", "alt_gnt1", 32'(obs_g1), 32'(i % 2 == 1));
    end

    // Preload word 0 and word 1 through port 1
    idle_all();
    setp(1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h000080FF);
    cyc("pre");
    setp(1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h4, 32'h11223344);
    cyc("pre");
    idle_all();

    // Sign extension passthrough
    setp(0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 32'h0, 32'h0);
    cyc("sext");
    chk("sext", "byte_sx", obs_rd0, 32'hFFFFFFFF);
    setp(0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 32'h0, 32'h0);
    cyc("sext");
    chk("sext", "half_zx", obs_rd0, 32'h000080FF);

    // Locked read-modify-write on port 1 while port 0 waits
    setp(0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    setp(1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    cyc("rmw");
    chk("rmw", "c1_gnt1", 32'(obs_g1), 32'h1);
    setp(1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    cyc("rmw");
    chk("rmw", "c2_gnt1", 32'(obs_g1), 32'h1);
    setp(1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    cyc("rmw");
    chk("rmw", "c3_gnt0", 32'(obs_g0), 32'h1);
    setp(0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    cyc("rmw");
    chk("rmw", "readback", obs_rd0, 32'hDEADBEEF);

    // Hold limit: port 0 keeps lock while port 1 also requests
    idle_all();
    setp(0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    cyc("hold");
    n0 = obs_g0 ? 1 : 0;
    saw_g1 = 1'b0;
    setp(1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'hC, 32'h0);
    for (int i = 0; i < 8 && !saw_g1; i++) begin
      cyc("hold");
      if (obs_g1) saw_g1 = 1'b1;
      else if (obs_g0) n0++;
    end
    chk("hold", "gnt0_count", 32'(n0), 32'(MAX_HOLD));
    chk("hold", "then_gnt1", 32'(saw_g1), 32'h1);

    // Misaligned word store must not write
    idle_all();
    setp(0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h6, 32'hCAFEF00D);
    cyc("mis");
    chk("mis", "mem_we", 32'(obs_mwe), 32'h0);
    chk("mis", "rvalid0", 32'(obs_rv0), 32'h1);
    chk("mis", "err0", 32'(obs_err0), 32'h1);
    chk("mis", "word1_mem", env_mem[1], 32'h11223344);
    setp(0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    cyc("mis");
    chk("mis", "word1_read", obs_rd0, 32'h11223344);

    // Reset while port 1 owns the memory
    idle_all();
    setp(1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    cyc("rstlk");
    t_req = 2'b11;
    rst = 1'b1;
    #1;
    chk_all_zero("rstlk");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    setp(0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    setp(1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    cyc("rstlk");
    chk("rstlk", "first_gnt0", 32'(obs_g0), 32'h1);
    cyc("rstlk");
    chk("rstlk", "second_gnt1", 32'(obs_g1), 32'h1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 2; p++) begin
        setp(p, ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
             1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom);
      end
      cyc("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single-cycle data memory between the core load/store path (port 0) and the DMA/debug requester (port 1). It grants at most one access per cycle and drives the memory's write-enable, size, sign-extend, address and write-data inputs. It registers read data, ack and misalignment error back to the granted port one cycle later. It also supports short locked sequences, such as read-modify-write, bounded by a hold limit.

## Interface
- MAX_HOLD, 4, max consecutive grants one port may hold in a locked sequence (≥1)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req0/req1  in  1  access request, held until gnt
- lock0/lock1  in  1  keep ownership after this access
- we0/we1  in  1  1 = store, 0 = load
- size0/size1  in  2  00 byte, 01 half, 10 word, 11 illegal
- sext0/sext1  in  1  load sign-extend
- addr0/addr1  in  32  byte address
- wd0/wd1  in  32  store data
- gnt0/gnt1  out  1  combinational; access issued this cycle
- rvalid0/rvalid1  out  1  registered response pulse
- rdata0/rdata1  out  32  registered load data
- err0/err1  out  1  registered misalignment error, valid with rvalid
- mem_we  out  1  to memory WE
- mem_size  out  2  to memory MemSize
- mem_sext  out  1  to memory ExtSign
- mem_addr  out  32  to memory addr
- mem_wd  out  32  to memory WD
- mem_rd  in  32  combinational read data from memory

## Operation
- States: IDLE, OWN0, OWN1. Registers: last (last granted port), hold_cnt.
- IDLE arbitration:
  - Single requester wins.
  - When both request, the port ≠ last wins (round-robin).
- On a grant in IDLE:
  - last ← winner.
  - If the winner's lock = 1: go to OWNwinner, hold_cnt ← 1. Otherwise stay in IDLE.
- OWNi:
  - Only port i may be granted. The other port's req is ignored.
  - If req_i = 1: gnt_i = 1, hold_cnt += 1.
  - Leave to IDLE when that access has lock_i = 0, or when hold_cnt reaches MAX_HOLD (forced release).
  - If req_i = 0: no grant that cycle, go to IDLE.
- Misalignment check on the granted request:
  - size 01 requires addr[0] = 0.
  - size 10 requires addr[1:0] = 00.
  - size 11 is always an error.
- A misaligned access is still granted, but mem_we is forced to 0 and the response has err = 1 and rdata = 0.
- Memory drive:
  - Granted cycle: mux the winner's we/size/sext/addr/wd to mem_*.
  - No grant: all mem_* = 0 (so mem_we = 0).
- Response, one cycle after each grant:
  - rvalid pulses for loads and stores.
  - rdata = mem_rd for aligned loads, 0 for stores and errors.
- rvalid of the non-granted port stays 0.

## Timing
- gnt is combinational from state, req, lock and last. The store commits at the same clk edge that ends the grant cycle.
- Response latency is exactly one cycle: rvalid/rdata/err are registered at the grant edge.
- Throughput is one access per cycle. Back-to-back grants to alternating ports are allowed.
- Reset values: state IDLE, last = 1 (port 0 wins the first contention), hold_cnt = 0, all rvalid/err = 0, all rdata = 0.
- Reset mid-sequence abandons the lock. Any response pending for the cycle is dropped.
- A requester deasserting req without gnt is legal. No response is produced.
- With MAX_HOLD = 1, lock has no effect beyond a single access.

## Structure
- Shared package dmem_pkg holds:
  - size encodings SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10
  - arbiter state encoding
  - misalignment rule function, shared with the memory so both agree
- Sub-module dmem_misalign_chk (size, addr → misalign), a combinational helper instantiated once on the muxed request.

## Test plan
- Contention after reset:
  - Stimulus: req0 and req1 both 1 each cycle, lock = 0.
  - Required: grants alternate 0, 1, 0, 1; each rvalid appears one cycle after its gnt.
- Locked read-modify-write:
  - Stimulus: port 1 lock = 1 loads word 0x10 then stores 0xDEADBEEF with lock = 0, while req0 is held.
  - Required: gnt1 on two consecutive cycles, gnt0 on the third; a later read of 0x10 returns 0xDEADBEEF.
- Hold limit:
  - Stimulus: MAX_HOLD = 4; port 0 holds lock = 1 and req0 continuously while req1 = 1.
  - Required: exactly 4 gnt0, then gnt1.
- Misaligned access:
  - Stimulus: port 0 store, size 10, addr 0x6.
  - Required: mem_we = 0; next cycle rvalid0 = 1, err0 = 1; memory word 1 unchanged.
- Sign extension passthrough:
  - Stimulus: memory word 0 = 0x000080FF.
  - Required: load byte, sext = 1, addr 0 → rdata 0xFFFFFFFF; load half, sext = 0, addr 0 → 0x000080FF.
- Reset during lock:
  - Stimulus: assert rst while in OWN1.
  - Required: all outputs 0 immediately; after release, contention grants port 0 first.
